// File: rtl/pwm_multi.sv
// rtl/pwm_multi.sv - multi-channel PWM with shared prescaled time base and double-buffered settings
module pwm_multi #(
    parameter int NUM_CH         = 4,
    parameter int COUNTER_WIDTH  = 8,
    parameter int PRESCALE_WIDTH = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            enable_i,
    input  logic [PRESCALE_WIDTH-1:0]       prescale_i,
    input  logic [COUNTER_WIDTH-1:0]        period_i,
    input  logic                            center_mode_i,
    input  logic [NUM_CH*COUNTER_WIDTH-1:0] cmp_value_i,
    input  logic [NUM_CH-1:0]               polarity_i,
    input  logic                            update_req_i,
    output logic                            update_ack_o,
    output logic                            period_start_o,
    output logic [NUM_CH-1:0]               pwm_o
);

    localparam int CW = COUNTER_WIDTH;

    logic [PRESCALE_WIDTH-1:0] presc;
    logic [CW-1:0]             cnt;
    logic                      dir_down;
    logic                      pending;
    logic [CW-1:0]             act_period;
    logic                      act_center;
    logic [NUM_CH*CW-1:0]      act_cmp;
    logic [NUM_CH-1:0]         act_pol;
    logic [NUM_CH-1:0]         raw;
    logic                      tick;
    logic                      boundary;
    logic                      load;

    // Time-base decode: prescaler tick, period boundary, shadow load and raw compare results
    always_comb begin
        tick     = enable_i && (presc == prescale_i);
        boundary = 1'b0;
        if (tick) begin
            if (!act_center)
                boundary = (cnt == act_period);
            else
                boundary = (dir_down && (cnt == {{(CW-1){1'b0}}, 1'b1})) || (act_period == '0);
        end
        // While stopped there is no boundary to wait for, so a request is taken at once
        load = (pending || update_req_i) && (boundary || !enable_i);
        raw  = '0;
        for (int k = 0; k < NUM_CH; k++)
            raw[k] = (cnt < act_cmp[k*CW +: CW]);
    end

    // Prescaler: free-runs 0..prescale_i while enabled, parked at 0 otherwise
    always_ff @(posedge clk) begin
        if (!rst_n || !enable_i)
            presc <= '0;
        else if (tick)
            presc <= '0;
        else
            presc <= presc + 1'b1;
    end

    // Period counter: edge mode wraps at period, center mode bounces between 0 and period
    always_ff @(posedge clk) begin
        if (!rst_n || !enable_i) begin
            cnt      <= '0;
            dir_down <= 1'b0;
        end else if (tick) begin
            if (boundary) begin
                cnt      <= '0;
                dir_down <= 1'b0;
            end else if (!act_center) begin
                cnt <= cnt + 1'b1;
            end else if (!dir_down) begin
                // Flag the turn as the counter reaches period so period == 1 still works
                cnt <= cnt + 1'b1;
                if (cnt == act_period - 1'b1)
                    dir_down <= 1'b1;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    // Shadow registers and pending request; active settings change only on a load
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending    <= 1'b0;
            act_period <= '1;
            act_center <= 1'b0;
            act_cmp    <= '0;
            act_pol    <= '0;
        end else if (load) begin
            pending    <= 1'b0;
            act_period <= period_i;
            act_center <= center_mode_i;
            act_cmp    <= cmp_value_i;
            act_pol    <= polarity_i;
        end else if (update_req_i) begin
            pending <= 1'b1;
        end
    end

    // Registered outputs; disabled channels sit at their inactive (polarity) level
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pwm_o          <= '0;
            period_start_o <= 1'b0;
            update_ack_o   <= 1'b0;
        end else begin
            pwm_o          <= enable_i ? (raw ^ act_pol) : act_pol;
            period_start_o <= boundary;
            update_ack_o   <= load;
        end
    end

endmodule

// File: tb/tb_pwm_multi.sv
// tb/tb_pwm_multi.sv - self-checking bench for pwm_multi against a position-based reference model
module tb_pwm_multi;

    localparam int NCH = 4;
    localparam int CW  = 8;
    localparam int PW  = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              enable_i;
    logic [PW-1:0]     prescale_i;
    logic [CW-1:0]     period_i;
    logic              center_mode_i;
    logic [NCH*CW-1:0] cmp_value_i;
    logic [NCH-1:0]    polarity_i;
    logic              update_req_i;
    logic              update_ack_o;
    logic              period_start_o;
    logic [NCH-1:0]    pwm_o;

    always #5 clk = ~clk;

    pwm_multi #(.NUM_CH(NCH), .COUNTER_WIDTH(CW), .PRESCALE_WIDTH(PW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable_i       (enable_i),
        .prescale_i     (prescale_i),
        .period_i       (period_i),
        .center_mode_i  (center_mode_i),
        .cmp_value_i    (cmp_value_i),
        .polarity_i     (polarity_i),
        .update_req_i   (update_req_i),
        .update_ack_o   (update_ack_o),
        .period_start_o (period_start_o),
        .pwm_o          (pwm_o)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: position within the period, derived counter value
    int             m_presc;
    int             m_pos;
    int             m_period;
    bit             m_center;
    bit             m_pending;
    int             m_cmp [NCH];
    logic [NCH-1:0] m_pol;
    logic [NCH-1:0] m_pwm;
    logic           m_ps;
    logic           m_ack;

    int win_hi [NCH];
    int win_ps;

    function automatic int m_len();
        if (!m_center) return m_period + 1;
        if (m_period == 0) return 1;
        return 2 * m_period;
    endfunction

    function automatic int m_cnt();
        if (m_center && m_pos > m_period) return 2 * m_period - m_pos;
        return m_pos;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        logic [NCH-1:0] raw;
        bit tick, bnd, ld;
        if (!rst_n) begin
            m_presc = 0; m_pos = 0; m_pending = 0;
            m_period = (1 << CW) - 1; m_center = 0; m_pol = '0;
            for (int k = 0; k < NCH; k++) m_cmp[k] = 0;
            m_pwm = '0; m_ps = 0; m_ack = 0;
        end else begin
            for (int k = 0; k < NCH; k++) raw[k] = (m_cnt() < m_cmp[k]);
            if (!enable_i) begin
                ld = m_pending || update_req_i;
                m_pwm = m_pol; m_ps = 0; m_presc = 0; m_pos = 0;
            end else begin
                tick = (m_presc == int'(prescale_i));
                bnd  = tick && (m_pos == m_len() - 1);
                ld   = bnd && (m_pending || update_req_i);
                m_pwm = raw ^ m_pol;
                m_ps  = bnd;
                m_presc = tick ? 0 : (m_presc + 1) % (1 << PW);
                if (tick) m_pos = bnd ? 0 : m_pos + 1;
            end
            m_ack = ld;
            if (ld) begin
                m_pending = 0;
                m_period  = int'(period_i);
                m_center  = center_mode_i;
                m_pol     = polarity_i;
                for (int k = 0; k < NCH; k++) m_cmp[k] = int'(cmp_value_i[k*CW +: CW]);
            end else if (update_req_i) begin
                m_pending = 1;
            end
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check("pwm_o", 32'(pwm_o), 32'(m_pwm));
        check("period_start_o", 32'(period_start_o), 32'(m_ps));
        check("update_ack_o", 32'(update_ack_o), 32'(m_ack));
    endtask

    task automatic pulse_req();
        update_req_i = 1'b1;
        step();
        update_req_i = 1'b0;
    endtask

    task automatic wait_ack(input int budget);
        bit seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            step();
            if (update_ack_o === 1'b1) seen = 1;
        end
        check("ack_wait", 32'(seen), 32'd1);
    endtask

    task automatic wait_ps(input int budget);
        bit seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            step();
            if (period_start_o === 1'b1) seen = 1;
        end
        check("period_start_wait", 32'(seen), 32'd1);
    endtask

    task automatic window(input int n);
        for (int k = 0; k < NCH; k++) win_hi[k] = 0;
        win_ps = 0;
        for (int i = 0; i < n; i++) begin
            step();
            for (int k = 0; k < NCH; k++) if (pwm_o[k] === 1'b1) win_hi[k]++;
            if (period_start_o === 1'b1) win_ps++;
        end
    endtask

    initial begin
        rst_n = 1'b0; enable_i = 1'b0; prescale_i = '0; period_i = '0;
        center_mode_i = 1'b0; cmp_value_i = '0; polarity_i = '0; update_req_i = 1'b0;
        step();
        step();
        check("reset_pwm", 32'(pwm_o), 32'd0);
        check("reset_ps", 32'(period_start_o), 32'd0);
        check("reset_ack", 32'(update_ack_o), 32'd0);

        // Edge mode, period 9, channel duty 3/0/10/9 out of 10
        rst_n = 1'b1; enable_i = 1'b1; period_i = 8'd9;
        cmp_value_i = {8'd9, 8'd10, 8'd0, 8'd3};
        pulse_req();
        wait_ack(300);
        window(10);
        check("edge_ch0_high", win_hi[0], 3);
        check("edge_ch1_high", win_hi[1], 0);
        check("edge_ch2_high", win_hi[2], 10);
        check("edge_ch3_high", win_hi[3], 9);
        check("edge_ps_count", win_ps, 1);

        // Inverted channel 0
        polarity_i = 4'b0001;
        pulse_req();
        wait_ack(30);
        window(10);
        check("pol_ch0_high", win_hi[0], 7);
        check("pol_ch3_high", win_hi[3], 9);

        // Mid-period compare change 3 -> 7
        polarity_i = 4'b0000;
        cmp_value_i = {8'd9, 8'd10, 8'd0, 8'd3};
        pulse_req();
        wait_ack(30);
        wait_ps(30);
        for (int i = 0; i < 5; i++) step();
        cmp_value_i = {8'd9, 8'd10, 8'd0, 8'd7};
        pulse_req();
        wait_ack(30);
        check("ack_with_period_start", 32'(period_start_o), 32'd1);
        window(10);
        check("mid_update_ch0_high", win_hi[0], 7);

        // Request in the very cycle of the boundary tick
        wait_ps(30);
        for (int i = 0; i < 9; i++) step();
        cmp_value_i = {8'd9, 8'd10, 8'd0, 8'd5};
        pulse_req();
        check("same_cycle_ack", 32'(update_ack_o), 32'd1);
        check("same_cycle_ps", 32'(period_start_o), 32'd1);

        // Center mode, period 4, prescale 1 -> 16-clock period, ch0 high 6
        prescale_i = 4'd1; period_i = 8'd4; center_mode_i = 1'b1;
        cmp_value_i = {8'd9, 8'd10, 8'd0, 8'd2};
        pulse_req();
        wait_ack(40);
        window(16);
        check("center_ch0_high", win_hi[0], 6);
        check("center_ps_count", win_ps, 1);
        window(32);
        check("center_ps_two", win_ps, 2);

        // Disable mid-period with a pending polarity change
        wait_ps(40);
        for (int i = 0; i < 3; i++) step();
        polarity_i = 4'b1010;
        pulse_req();
        enable_i = 1'b0;
        step();
        check("disable_ack", 32'(update_ack_o), 32'd1);
        step();
        check("disable_pwm", 32'(pwm_o), 32'hA);
        enable_i = 1'b1;
        step();
        check("reenable_no_ps", 32'(period_start_o), 32'd0);
        for (int i = 0; i < 7; i++) step();

        // Reset while running
        rst_n = 1'b0;
        step();
        check("midrun_reset_pwm", 32'(pwm_o), 32'd0);
        check("midrun_reset_ps", 32'(period_start_o), 32'd0);
        rst_n = 1'b1;

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            rst_n         = ($urandom_range(0, 299) != 0);
            enable_i      = ($urandom_range(0, 24) != 0);
            update_req_i  = ($urandom_range(0, 5) == 0);
            period_i      = 8'($urandom_range(0, 12));
            center_mode_i = 1'($urandom_range(0, 1));
            polarity_i    = 4'($urandom_range(0, 15));
            for (int k = 0; k < NCH; k++) cmp_value_i[k*CW +: CW] = 8'($urandom_range(0, 14));
            if ($urandom_range(0, 49) == 0) prescale_i = 4'($urandom_range(0, 2));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
